// File: rtl/generic_bus_burst_adapter.sv
// rtl/generic_bus_burst_adapter.sv - splits one block-wide request into single-word beats
// INCR or WRAP (critical-word-first) ordering; first downstream error aborts the burst.
module generic_bus_burst_adapter #(
  parameter int BLOCK_SIZE    = 4,
  parameter int BURST_MODE    = 0,
  parameter int RAM_ADDR_SIZE = 32,
  parameter int WORD_SIZE     = 32
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [RAM_ADDR_SIZE-1:0]        up_addr,
  input  logic                            up_ren,
  input  logic                            up_wen,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] up_wdata,
  input  logic [3:0]                      up_byte_en,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] up_rdata,
  output logic                            up_busy,
  output logic                            up_error,
  output logic [RAM_ADDR_SIZE-1:0]        dn_addr,
  output logic                            dn_ren,
  output logic                            dn_wen,
  output logic [WORD_SIZE-1:0]            dn_wdata,
  output logic [3:0]                      dn_byte_en,
  input  logic [WORD_SIZE-1:0]            dn_rdata,
  input  logic                            dn_busy,
  input  logic                            dn_error
);

  localparam int IDXW = $clog2(BLOCK_SIZE);
  localparam int OFFW = IDXW + 2;
  localparam logic [RAM_ADDR_SIZE-1:0] OFF_MASK = RAM_ADDR_SIZE'((1 << OFFW) - 1);

  typedef enum logic [1:0] {IDLE, BEAT, DONE, ERR} state_t;

  state_t                            state;
  logic [IDXW-1:0]                   c;
  logic [IDXW-1:0]                   s_l;
  logic                              write_l;
  logic                              err_flag;
  logic [RAM_ADDR_SIZE-1:0]          base_l;
  logic [WORD_SIZE*BLOCK_SIZE-1:0]   wdata_l;

  logic [IDXW-1:0]                   up_s;
  logic [IDXW-1:0]                   w0;
  logic [IDXW-1:0]                   w_cur;
  logic [IDXW-1:0]                   w_next;
  logic [RAM_ADDR_SIZE-1:0]          up_base;
  logic [WORD_SIZE-1:0]              up_word0;
  logic [WORD_SIZE-1:0]              next_word;
  logic                              last_beat;

  function automatic logic [RAM_ADDR_SIZE-1:0] word_addr(
    input logic [RAM_ADDR_SIZE-1:0] base,
    input logic [IDXW-1:0]          w
  );
    return base | {{(RAM_ADDR_SIZE-OFFW){1'b0}}, w, 2'b00};
  endfunction

  // The word index wraps naturally in IDXW bits, which gives both INCR and WRAP order.
  always_comb begin
    up_s      = up_addr[OFFW-1:2];
    up_base   = up_addr & ~OFF_MASK;
    w0        = (BURST_MODE != 0) ? up_s : '0;
    w_cur     = (BURST_MODE != 0) ? (s_l + c) : c;
    w_next    = w_cur + 1'b1;
    last_beat = (c == IDXW'(BLOCK_SIZE - 1));
    up_word0  = '0;
    next_word = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (w0 == IDXW'(i)) up_word0 = up_wdata[i*WORD_SIZE +: WORD_SIZE];
      if (w_next == IDXW'(i)) next_word = wdata_l[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      c          <= '0;
      s_l        <= '0;
      write_l    <= 1'b0;
      err_flag   <= 1'b0;
      base_l     <= '0;
      wdata_l    <= '0;
      up_rdata   <= '0;
      dn_addr    <= '0;
      dn_wdata   <= '0;
      dn_byte_en <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up_ren && up_wen) begin
            state <= ERR;
          end else if (up_ren || up_wen) begin
            state      <= BEAT;
            c          <= '0;
            err_flag   <= 1'b0;
            s_l        <= up_s;
            write_l    <= up_wen;
            base_l     <= up_base;
            wdata_l    <= up_wdata;
            dn_addr    <= word_addr(up_base, w0);
            dn_wdata   <= up_wen ? up_word0 : '0;
            dn_byte_en <= up_byte_en;
          end
        end
        BEAT: begin
          if (!dn_busy) begin
            if (!write_l) begin
              for (int i = 0; i < BLOCK_SIZE; i++) begin
                if (w_cur == IDXW'(i)) up_rdata[i*WORD_SIZE +: WORD_SIZE] <= dn_rdata;
              end
            end
            if (dn_error || last_beat) begin
              err_flag <= dn_error;
              state    <= DONE;
            end else begin
              c        <= c + 1'b1;
              dn_addr  <= word_addr(base_l, w_next);
              dn_wdata <= write_l ? next_word : '0;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state flops.
  assign up_busy  = !(state == DONE || state == ERR);
  assign up_error = (state == ERR) || (state == DONE && err_flag);
  assign dn_ren   = (state == BEAT) && !write_l;
  assign dn_wen   = (state == BEAT) && write_l;

endmodule

// File: tb/tb_generic_bus_burst_adapter.sv
// tb/tb_generic_bus_burst_adapter.sv - bench for generic_bus_burst_adapter
// Runs an INCR and a WRAP instance side by side on identical stimulus.
module tb_generic_bus_burst_adapter;
  localparam int BS = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [31:0]  up_addr;
  logic         up_ren, up_wen;
  logic [127:0] up_wdata;
  logic [3:0]   up_byte_en;
  logic         dn_busy, dn_error;

  logic [127:0] up_rdata_o [2];
  logic         up_busy_o  [2];
  logic         up_error_o [2];
  logic [31:0]  dn_addr_o  [2];
  logic [31:0]  dn_wdata_o [2];
  logic [31:0]  dn_rdata_i [2];
  logic         dn_ren_o   [2];
  logic         dn_wen_o   [2];
  logic [3:0]   dn_be_o    [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    assign dn_rdata_i[m] = dn_addr_o[m];
    generic_bus_burst_adapter #(.BLOCK_SIZE(BS), .BURST_MODE(m)) u_dut (
      .CLK(CLK), .RST(RST),
      .up_addr(up_addr), .up_ren(up_ren), .up_wen(up_wen),
      .up_wdata(up_wdata), .up_byte_en(up_byte_en),
      .up_rdata(up_rdata_o[m]), .up_busy(up_busy_o[m]), .up_error(up_error_o[m]),
      .dn_addr(dn_addr_o[m]), .dn_ren(dn_ren_o[m]), .dn_wen(dn_wen_o[m]),
      .dn_wdata(dn_wdata_o[m]), .dn_byte_en(dn_be_o[m]),
      .dn_rdata(dn_rdata_i[m]), .dn_busy(dn_busy), .dn_error(dn_error)
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic         chk_en;
  logic         exp_busy, exp_error, exp_ren, exp_wen, exp_dn;
  logic [3:0]   exp_be;
  logic [31:0]  exp_addr  [2];
  logic [31:0]  exp_wdata [2];
  logic [127:0] exp_rdata [2];

  int cyc = 0;
  int start_cyc = 0;
  int done_rel;
  int act_cnt [2];
  logic [31:0] log_incr [$];
  logic [31:0] log_wrap [$];

  task automatic check(input string name, input int m, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t got %h want %h", name, m, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] q[$]);
    logic [127:0] r = '0;
    for (int i = 0; i < q.size() && i < 4; i++) r[32*i +: 32] = q[i];
    return r;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Cycle n is the one between edge n-1 and edge n; edge 0 samples the request.
  always @(negedge CLK) begin
    if (chk_en && !up_busy_o[0] && done_rel < 0) done_rel <= cyc - start_cyc + 1;
    for (int m = 0; m < 2; m++) begin
      if (dn_ren_o[m] || dn_wen_o[m]) begin
        act_cnt[m] <= act_cnt[m] + 1;
        if (!dn_busy) begin
          if (m == 0) log_incr.push_back(dn_addr_o[m]);
          else        log_wrap.push_back(dn_addr_o[m]);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check("up_busy",  m, 128'(up_busy_o[m]),  128'(exp_busy));
        check("up_error", m, 128'(up_error_o[m]), 128'(exp_error));
        check("dn_ren",   m, 128'(dn_ren_o[m]),   128'(exp_ren));
        check("dn_wen",   m, 128'(dn_wen_o[m]),   128'(exp_wen));
        check("up_rdata", m, up_rdata_o[m],       exp_rdata[m]);
        if (exp_dn) begin
          check("dn_addr",    m, 128'(dn_addr_o[m]),  128'(exp_addr[m]));
          check("dn_wdata",   m, 128'(dn_wdata_o[m]), 128'(exp_wdata[m]));
          check("dn_byte_en", m, 128'(dn_be_o[m]),    128'(exp_be));
        end
      end
    end
  end

  task automatic set_reset_exp();
    exp_busy = 1'b1; exp_error = 1'b0; exp_ren = 1'b0; exp_wen = 1'b0;
    exp_dn = 1'b1; exp_be = 4'h0;
    for (int m = 0; m < 2; m++) begin
      exp_addr[m] = '0; exp_wdata[m] = '0; exp_rdata[m] = '0;
    end
  endtask

  function automatic int word_of(input int m, input logic [31:0] addr, input int k);
    int s = int'(addr[3:2]);
    return (m == 1) ? (s + k) % BS : k;
  endfunction

  task automatic set_beat_exp(input int k, input logic ren, input logic wen, input logic [31:0] addr,
                              input logic [127:0] wdata, input logic [3:0] be);
    logic [31:0] base = addr & ~32'hF;
    for (int m = 0; m < 2; m++) begin
      int w = word_of(m, addr, k);
      exp_addr[m]  = base + 32'(4 * w);
      exp_wdata[m] = wen ? wdata[32*w +: 32] : 32'h0;
    end
    exp_busy = 1'b1; exp_error = 1'b0; exp_ren = ren; exp_wen = wen;
    exp_dn = 1'b1; exp_be = be;
  endtask

  task automatic run_txn(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [127:0] wdata, input logic [3:0] be,
                         input int waits, input int err_beat, input bit scramble);
    logic [31:0] base = addr & ~32'hF;
    int nb;
    nb = (ren && wen) ? 0 : ((err_beat >= 0) ? err_beat + 1 : BS);
    up_ren = ren; up_wen = wen; up_addr = addr; up_wdata = wdata; up_byte_en = be;
    act_cnt[0] = 0; act_cnt[1] = 0; done_rel = -1;
    log_incr.delete(); log_wrap.delete();
    @(posedge CLK); #1;
    start_cyc = cyc;
    if (scramble) begin
      up_addr = ~addr; up_wdata = ~wdata; up_byte_en = ~be;
    end
    for (int k = 0; k < nb; k++) begin
      set_beat_exp(k, ren, wen, addr, wdata, be);
      for (int t = 0; t <= waits; t++) begin
        dn_busy  = (t < waits);
        dn_error = (t == waits) && (k == err_beat);
        @(posedge CLK); #1;
      end
      if (ren) begin
        for (int m = 0; m < 2; m++) begin
          int w = word_of(m, addr, k);
          exp_rdata[m][32*w +: 32] = base + 32'(4 * w);
        end
      end
    end
    dn_busy = 1'b1; dn_error = 1'b0; up_ren = 1'b0; up_wen = 1'b0;
    exp_busy = 1'b0; exp_error = (ren && wen) || (err_beat >= 0);
    exp_ren = 1'b0; exp_wen = 1'b0; exp_dn = 1'b0;
    @(posedge CLK); #1;
    exp_busy = 1'b1; exp_error = 1'b0;
  endtask

  initial begin
    RST = 1'b1; chk_en = 1'b0; done_rel = -1;
    up_addr = '0; up_ren = 1'b0; up_wen = 1'b0; up_wdata = '0; up_byte_en = '0;
    dn_busy = 1'b1; dn_error = 1'b0;
    act_cnt[0] = 0; act_cnt[1] = 0;
    set_reset_exp();
    @(posedge CLK); #1;
    chk_en = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // INCR / WRAP read at 0x108, zero wait, memory word at A is A
    run_txn(1'b1, 1'b0, 32'h108, '0, 4'hF, 0, -1, 1'b0);
    check("rd_done_cycle", 0, 128'(done_rel), 128'd5);
    check("rd_rdata", 0, up_rdata_o[0], 128'h0000010C_00000108_00000104_00000100);
    check("rd_rdata", 1, up_rdata_o[1], 128'h0000010C_00000108_00000104_00000100);
    check("rd_order", 0, pack4(log_incr), 128'h0000010C_00000108_00000104_00000100);
    check("rd_order", 1, pack4(log_wrap), 128'h00000104_00000100_0000010C_00000108);

    // Write {D,C,B,A}, byte_en 3, two wait cycles per beat
    run_txn(1'b0, 1'b1, 32'h104, {32'hD, 32'hC, 32'hB, 32'hA}, 4'h3, 2, -1, 1'b0);
    check("wr_done_cycle", 0, 128'(done_rel), 128'd13);
    check("wr_active_cycles", 0, 128'(act_cnt[0]), 128'd12);

    // Read aborted by an error on the second beat
    run_txn(1'b1, 1'b0, 32'h208, '0, 4'hF, 0, 1, 1'b0);
    check("err_done_cycle", 0, 128'(done_rel), 128'd3);
    check("err_beats", 0, 128'(act_cnt[0]), 128'd2);
    check("err_rdata", 0, up_rdata_o[0], 128'h0000010C_00000108_00000204_00000200);
    check("err_rdata", 1, up_rdata_o[1], 128'h0000020C_00000208_00000104_00000100);

    // Both ren and wen: immediate error completion, no beats
    run_txn(1'b1, 1'b1, 32'h400, '0, 4'hF, 0, -1, 1'b0);
    check("both_done_cycle", 0, 128'(done_rel), 128'd1);
    check("both_beats", 0, 128'(act_cnt[0] + act_cnt[1]), 128'd0);

    // Upstream inputs change mid-burst; latched values must be used
    run_txn(1'b0, 1'b1, 32'h3F4, 128'h44444444_33333333_22222222_11111111, 4'h5, 1, -1, 1'b1);
    run_txn(1'b1, 1'b0, 32'h3F4, '0, 4'h5, 1, -1, 1'b1);
    check("scr_rdata", 1, up_rdata_o[1], 128'h000003FC_000003F8_000003F4_000003F0);

    // Reset in the middle of the first beat, then a fresh read
    up_ren = 1'b1; up_wen = 1'b0; up_addr = 32'h308; up_wdata = '0; up_byte_en = 4'hF;
    @(posedge CLK); #1;
    set_beat_exp(0, 1'b1, 1'b0, 32'h308, '0, 4'hF);
    dn_busy = 1'b1; RST = 1'b1; up_ren = 1'b0;
    @(posedge CLK); #1;
    set_reset_exp();
    RST = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    run_txn(1'b1, 1'b0, 32'h108, '0, 4'hF, 0, -1, 1'b0);
    check("rst_rd_done_cycle", 0, 128'(done_rel), 128'd5);
    check("rst_rd_rdata", 0, up_rdata_o[0], 128'h0000010C_00000108_00000104_00000100);

    @(posedge CLK); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/generic_bus_burst_adapter.md
# generic_bus_burst_adapter

Parametrised bridge that turns one block-wide generic-bus request (BLOCK_SIZE words) from a cache or DMA requester into a sequence of single-word generic-bus transactions toward memory. It supports incrementing or wrapping (critical-word-first) bursts and aborts a burst on the first downstream error. It sits between a block-level requester and the single-word memory/bus-arbiter port.

## Interface
- BLOCK_SIZE, 4: words per upstream transaction; power of two, 2 to 16.
- BURST_MODE, 0: 0 = INCR (words start at the block base and ascend), 1 = WRAP (start at the requested word, wrap inside the block-aligned window).
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- up_addr  input  RAM_ADDR_SIZE  upstream byte address.
- up_ren, up_wen  input  1 each  upstream read/write request; held until up_busy is low.
- up_wdata  input  WORD_SIZE*BLOCK_SIZE  write block; word i at bits [32i+31:32i].
- up_byte_en  input  4  byte enables applied to every beat.
- up_rdata  output  WORD_SIZE*BLOCK_SIZE  assembled read block.
- up_busy  output  1  low for exactly one cycle when the transaction completes.
- up_error  output  1  valid in the completion cycle.
- dn_addr  output  RAM_ADDR_SIZE  beat address, word-aligned.
- dn_ren, dn_wen  output  1 each  beat request.
- dn_wdata  output  WORD_SIZE  beat write data.
- dn_byte_en  output  4  beat byte enables.
- dn_rdata  input  WORD_SIZE  beat read data; valid when dn_busy is low.
- dn_busy, dn_error  input  1 each  beat completion and error, sampled when dn_busy is low.

## Operation
- FSM states: IDLE, BEAT, DONE, ERR.
- IDLE
  - Exactly one of up_ren or up_wen high: latch the address, the start word s, the op, up_wdata and up_byte_en. Clear the beat counter c and the error flag. Go to BEAT.
  - up_ren and up_wen both high: go to ERR. No downstream access is made.
- Start word: s = up_addr[log2(BLOCK_SIZE)+1:2]. Block base: the latched address with its low log2(BLOCK_SIZE)+2 bits cleared.
- Word index w:
  - INCR: w = c, and the address is base + 4c.
  - WRAP: w = (s + c) mod BLOCK_SIZE, and the address is base + 4w.
  - Address arithmetic is modulo 2^RAM_ADDR_SIZE. Bits [1:0] are always 0.
- BEAT
  - Drive dn_ren or dn_wen for the latched op.
  - Drive dn_addr, dn_byte_en, and dn_wdata = latched word w. dn_wdata is 0 on reads.
  - On a cycle with dn_busy low:
    - Read: write dn_rdata into up_rdata word w.
    - dn_error high: set the error flag and go to DONE. Remaining beats are abandoned.
    - Otherwise, c = BLOCK_SIZE-1: go to DONE.
    - Otherwise: c increments and the FSM stays in BEAT. The next beat's request follows with no idle cycle.
- DONE: up_busy = 0 and up_error = error flag for one cycle, then go to IDLE.
- ERR: up_busy = 0 and up_error = 1 for one cycle, then go to IDLE.
- up_rdata holds its value between transactions. Only read beats modify it. After an aborted read, words that were never fetched keep their old contents.
- A request still held in the cycle after completion is taken as a new transaction (back-to-back).

## Timing
- Reset values, from the first edge with RST high: state IDLE, c = 0, up_busy = 1, up_error = 0, up_rdata = 0, dn_ren = dn_wen = 0, dn_addr = 0, dn_wdata = 0, dn_byte_en = 0.
- RST mid-burst: the outstanding beat is dropped after that edge and there is no completion pulse.
- Downstream outputs and up_busy/up_error are decoded from registered state only. There is no combinational path from up_* inputs or dn_busy to any output.
- Latency, request seen at edge 0 with zero-wait memory:
  - Beats occupy cycles 1 to BLOCK_SIZE.
  - up_busy is low in cycle BLOCK_SIZE+1.
  - Each downstream wait cycle adds one.
- ERR case: up_busy is low in cycle 1.
- The upstream inputs are latched at acceptance, so changes to them during a burst have no effect.

## Test plan
- INCR read, BLOCK_SIZE 4, up_addr 0x108, memory returns word at A = A, zero wait -> dn_addr 0x100, 0x104, 0x108, 0x10C in cycles 1–4; up_busy low in cycle 5; up_rdata = {0x10C, 0x108, 0x104, 0x100}; up_error 0.
- WRAP read, same request -> dn_addr 0x108, 0x10C, 0x100, 0x104; up_rdata identical to the INCR case.
- Write of {0xD, 0xC, 0xB, 0xA}, byte_en 0x3, 2 wait cycles per beat -> beats carry wdata A..D and byte_en 0x3; each request is held for 3 cycles; completion in cycle 13.
- Read with dn_error on beat 2 -> only 2 beats issued; up_busy low the next cycle with up_error 1; up_rdata words 2–3 unchanged.
- up_ren and up_wen both high -> no dn_ren/dn_wen; up_busy low with up_error 1 in cycle 1.
- RST asserted during beat 1, then a fresh read -> outputs return to reset values, no completion pulse; the new read completes normally.
